// File: rtl/asm_array_packer.sv
// rtl/asm_array_packer.sv - binary-activation kernel accumulator and multi-beat bit packer
// Each accepted sample adds +/-pix per channel; every KLEN taps yields one sign bit per channel, BEATS groups form a word.
module asm_array_packer #(
  parameter int NUM_CH = 8,
  parameter int PIX_W  = 16,
  parameter int BN_W   = 16,
  parameter int ACC_W  = 24,
  parameter int KLEN   = 9,
  parameter int BEATS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_W-1:0]          data_pix,
  input  logic [NUM_CH-1:0]         data_w,
  input  logic [NUM_CH*BN_W-1:0]    data_bn,
  output logic [NUM_CH*BEATS-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int OUT_W  = NUM_CH * BEATS;
  localparam int TAP_W  = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(KLEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

  logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [TAP_W-1:0]             tap_q, tap_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [OUT_W-1:0]             pack_q, pack_d;
  logic [OUT_W-1:0]             out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;

  logic                         last_tap, last_beat, accept, load;
  logic [ACC_W-1:0]             pix_ext, term, bn_ext;
  logic [NUM_CH-1:0]            bits;
  logic [OUT_W-1:0]             word_full;

  always_comb begin
    last_tap  = (tap_q == TAP_LAST);
    last_beat = (beat_q == BEAT_LAST);
    // Only the word-completing sample must wait for a free output register.
    in_ready  = !(out_valid_q && !out_ready && last_tap && last_beat);
    accept    = en && in_valid && in_ready;
    load      = accept && last_tap && last_beat;
    pix_ext   = {{(ACC_W-PIX_W){data_pix[PIX_W-1]}}, data_pix};

    acc_d  = acc_q;
    bits   = '0;
    term   = '0;
    bn_ext = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      term    = data_w[c] ? pix_ext : (ACC_W'(0) - pix_ext);
      bn_ext  = {{(ACC_W-BN_W){data_bn[c*BN_W+BN_W-1]}}, data_bn[c*BN_W +: BN_W]};
      bits[c] = ($signed(acc_q[c] + term + bn_ext) >= ACC_ZERO);
      acc_d[c] = last_tap ? '0 : (acc_q[c] + term);
    end

    word_full = pack_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) word_full[b*NUM_CH +: NUM_CH] = bits;
    end

    tap_d       = tap_q;
    beat_d      = beat_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (!en) begin
      acc_d  = '0;
      tap_d  = '0;
      beat_d = '0;
      pack_d = '0;
    end else if (accept) begin
      tap_d = last_tap ? '0 : (tap_q + 1'b1);
      if (last_tap) begin
        beat_d = last_beat ? '0 : (beat_q + 1'b1);
        pack_d = last_beat ? '0 : word_full;
      end
    end else begin
      acc_d = acc_q;
    end

    // The output handshake keeps running even while en is low.
    if (load) begin
      out_data_d  = word_full;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      tap_q       <= '0;
      beat_q      <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      beat_q      <= beat_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_asm_array_packer.sv
// tb/tb_asm_array_packer.sv - randomized and directed bench for asm_array_packer
// Reference keeps integer kernel sums and a per-word sample count.
module tb_asm_array_packer;

  localparam int NUM_CH = 8;
  localparam int PIX_W  = 16;
  localparam int BN_W   = 16;
  localparam int ACC_W  = 24;
  localparam int KLEN   = 9;
  localparam int BEATS  = 2;
  localparam int OUT_W  = NUM_CH * BEATS;
  localparam int WORD_N = KLEN * BEATS;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic                    in_valid;
  logic                    in_ready;
  logic [PIX_W-1:0]        data_pix;
  logic [NUM_CH-1:0]       data_w;
  logic [NUM_CH*BN_W-1:0]  data_bn;
  logic [OUT_W-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;

  asm_array_packer #(
    .NUM_CH(NUM_CH), .PIX_W(PIX_W), .BN_W(BN_W),
    .ACC_W(ACC_W), .KLEN(KLEN), .BEATS(BEATS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .data_pix(data_pix), .data_w(data_w), .data_bn(data_bn),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int               m_cnt;
  longint           m_sum [NUM_CH];
  logic [OUT_W-1:0] m_word;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             obs_ready;

  localparam logic [NUM_CH*BN_W-1:0] BN_M9 = {NUM_CH{16'hFFF7}};
  localparam logic [NUM_CH*BN_W-1:0] BN_0  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    for (int c = 0; c < NUM_CH; c++) m_sum[c] = 0;
    m_word  = '0;
    m_data  = '0;
    m_valid = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic e, input logic v, input logic [PIX_W-1:0] pix,
                      input logic [NUM_CH-1:0] w, input logic [NUM_CH*BN_W-1:0] bn,
                      input logic rdy);
    logic   exp_ready, accept, xfer, loaded;
    longint p, b;
    en = e; in_valid = v; data_pix = pix; data_w = w; data_bn = bn; out_ready = rdy;
    #1;
    exp_ready = !(m_valid && !rdy && (m_cnt == WORD_N - 1));
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    obs_ready = in_ready;

    accept = e && v && exp_ready;
    xfer   = m_valid && rdy;
    loaded = 1'b0;
    p      = longint'($signed(pix));
    if (!e) begin
      m_cnt  = 0;
      for (int c = 0; c < NUM_CH; c++) m_sum[c] = 0;
      m_word = '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++) m_sum[c] += w[c] ? p : -p;
      if ((m_cnt % KLEN) == KLEN - 1) begin
        for (int c = 0; c < NUM_CH; c++) begin
          b = longint'($signed(bn[c*BN_W +: BN_W]));
          m_word[(m_cnt / KLEN) * NUM_CH + c] = (m_sum[c] + b >= 0);
          m_sum[c] = 0;
        end
      end
      m_cnt++;
      if (m_cnt == WORD_N) begin
        m_data = m_word;
        m_word = '0;
        m_cnt  = 0;
        loaded = 1'b1;
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (xfer) m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_word(input logic [PIX_W-1:0] pix, input logic [NUM_CH-1:0] w,
                          input logic [NUM_CH*BN_W-1:0] bn, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, pix, w, bn, rdy);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; data_pix = '0; data_w = '0;
    data_bn = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // sum == 0 maps to bit 1
    run_word(16'd1, 8'hFF, BN_M9, 1'b1, WORD_N);
    check("r34_valid", out_valid, 1'b1);
    check("r34_word", out_data, 16'hFFFF);
    step(1'b1, 1'b0, '0, '0, BN_0, 1'b1);
    check("r34_one_cycle", out_valid, 1'b0);

    run_word(16'd5, 8'h01, BN_0, 1'b1, WORD_N);
    check("r35_word", out_data, 16'h0101);
    step(1'b1, 1'b0, '0, '0, BN_0, 1'b1);

    // Backpressure on the word-completing sample only
    run_word(16'd5, 8'h01, BN_0, 1'b0, WORD_N);
    run_word(16'd1, 8'hFF, BN_M9, 1'b0, WORD_N - 1);
    check("r36_ready_before", obs_ready, 1'b1);
    step(1'b1, 1'b1, 16'd1, 8'hFF, BN_M9, 1'b0);
    check("r36_stall", obs_ready, 1'b0);
    check("r36_hold", out_data, 16'h0101);
    step(1'b1, 1'b1, 16'd1, 8'hFF, BN_M9, 1'b1);
    check("r36_release", obs_ready, 1'b1);
    check("r36_second_valid", out_valid, 1'b1);
    check("r36_second_word", out_data, 16'hFFFF);
    step(1'b1, 1'b0, '0, '0, BN_0, 1'b1);

    // Abort a partial kernel with en low
    run_word(16'd7, 8'hA5, BN_0, 1'b1, 4);
    step(1'b0, 1'b1, 16'd7, 8'hA5, BN_0, 1'b1);
    run_word(16'd5, 8'h01, BN_0, 1'b1, WORD_N);
    check("r37_word", out_data, 16'h0101);
    step(1'b1, 1'b0, '0, '0, BN_0, 1'b1);

    // Most-negative pixel, no accumulator overflow
    run_word(16'h8000, 8'h00, BN_0, 1'b1, KLEN);
    run_word(16'h8000, 8'hFF, BN_0, 1'b1, KLEN);
    check("r38_word", out_data, 16'h00FF);
    step(1'b1, 1'b0, '0, '0, BN_0, 1'b1);

    // Reset mid-word
    run_word(16'd3, 8'h5A, BN_0, 1'b1, 10);
    do_reset();
    run_word(16'd1, 8'hFF, BN_M9, 1'b1, WORD_N);
    check("r39_word", out_data, 16'hFFFF);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 96), ($urandom_range(0, 99) < 80),
           PIX_W'($urandom), NUM_CH'($urandom),
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 99) < 60));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, '0, BN_0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
